sl_rx_param: RTL and testbench

SL_RX_PARAM -- requirements
Module: sl_rx_param

---
 rtl/sl_rx_param_if.sv | 24 ++
 rtl/sl_rx_param.sv | 188 ++++++++++++++++++
 tb/tb_sl_rx_param.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sl_rx_param_if.sv
// Output-side bundle of the two-line serial receiver: received word,
// valid/ready handshake, per-frame error pulses and frame-in-progress flag.
interface sl_rx_param_if #(
    parameter int MAX_BITS = 32
);
    logic [MAX_BITS-1:0] data_out;
    logic                out_valid;
    logic                out_ready;
    logic                err_parity;
    logic                err_length;
    logic                err_timeout;
    logic                overrun;
    logic                busy;

    modport master (
        output data_out, out_valid, err_parity, err_length, err_timeout, overrun, busy,
        input  out_ready
    );

    modport slave (
        input  data_out, out_valid, err_parity, err_length, err_timeout, overrun, busy,
        output out_ready
    );
endinterface

// File: rtl/sl_rx_param.sv
// Two-line serial receiver: each line is synchronised and glitch-filtered,
// bits are framed by a parity bit and a both-low STOP, words are held for a consumer.
module sl_rx_param #(
    parameter int MAX_BITS = 32,
    parameter int FILT_LEN = 3,
    parameter int TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sl0,
    input  logic                          sl1,
    input  logic [1:0]                    mode,
    input  logic [$clog2(MAX_BITS+1)-1:0] bit_len,
    sl_rx_param_if.master                 rx
);
    localparam int BLW = $clog2(MAX_BITS + 1);
    localparam int BCW = $clog2(MAX_BITS + 2);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int FW  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT_STOP, S_ERR_WAIT} state_t;

    state_t              state, nxt;
    logic [1:0]          sync1, sync2, filt, filt_d;
    logic [FW-1:0]       fcnt [2];
    logic [MAX_BITS-1:0] sr, data_q;
    logic [BCW-1:0]      bcnt, nlen, n_sel;
    logic [TW-1:0]       tcnt;
    logic                par, valid_q;
    logic                p_par_q, p_len_q, p_tmo_q, ovr_q;
    logic                ev_bit, ev_stop, ev_any, bit_val, lvl_idle, tmo_hit;
    logic                start, take, commit, p_par, p_len, p_tmo;
    int unsigned         len;

    // Index 0 carries sl0, index 1 carries sl1; filter only moves after FILT_LEN agreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            filt_d  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {sl1, sl0};
            sync2  <= sync1;
            filt_d <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bit_val  = filt_d[1] & ~filt[1] & filt[0];
        ev_bit   = bit_val | (filt_d[0] & ~filt[0] & filt[1]);
        ev_stop  = (filt_d != 2'b00) && (filt == 2'b00);
        ev_any   = (filt != filt_d);
        lvl_idle = &filt;
        tmo_hit  = !ev_any && (tcnt >= TW'(TIMEOUT - 1));
    end

    always_comb begin
        len = 0;
        unique case (mode)
            2'd0:    len = 8;
            2'd1:    len = 16;
            2'd2:    len = 32;
            default: len = {{(32 - BLW){1'b0}}, bit_len};
        endcase
        if (len == 0 || len > MAX_BITS) len = MAX_BITS;
        n_sel = BCW'(len);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt    = state;
        start  = 1'b0;
        take   = 1'b0;
        commit = 1'b0;
        p_par  = 1'b0;
        p_len  = 1'b0;
        p_tmo  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ev_bit) begin
                    start = 1'b1;
                    nxt   = S_RECV;
                end else if (ev_stop) begin
                    nxt = S_ERR_WAIT;
                end
            end
            S_RECV: begin
                if (ev_bit) begin
                    take = 1'b1;
                    if (bcnt == nlen) nxt = S_WAIT_STOP;
                end else if (ev_stop) begin
                    p_len = 1'b1;
                    nxt   = S_ERR_WAIT;
                end else if (tmo_hit) begin
                    p_tmo = 1'b1;
                    nxt   = S_ERR_WAIT;
                end
            end
            S_WAIT_STOP: begin
                if (ev_bit) begin
                    p_len = 1'b1;
                    nxt   = S_ERR_WAIT;
                end else if (ev_stop) begin
                    if (par) commit = 1'b1;
                    else     p_par  = 1'b1;
                    nxt = S_ERR_WAIT;
                end else if (tmo_hit) begin
                    p_tmo = 1'b1;
                    nxt   = S_ERR_WAIT;
                end
            end
            default: begin
                if (lvl_idle) nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            data_q  <= '0;
            bcnt    <= '0;
            nlen    <= '0;
            tcnt    <= '0;
            par     <= 1'b0;
            valid_q <= 1'b0;
            p_par_q <= 1'b0;
            p_len_q <= 1'b0;
            p_tmo_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            p_par_q <= p_par;
            p_len_q <= p_len;
            p_tmo_q <= p_tmo;
            ovr_q   <= commit && valid_q && !rx.out_ready;

            if (start) begin
                sr   <= MAX_BITS'(bit_val);
                bcnt <= BCW'(1);
                par  <= bit_val;
                nlen <= n_sel;
            end else if (take) begin
                // Positions below nlen are data; the bit at nlen is parity only.
                if (bcnt < nlen) sr <= sr | (MAX_BITS'(bit_val) << bcnt);
                par <= par ^ bit_val;
                if (bcnt <= nlen) bcnt <= bcnt + 1'b1;
            end

            if ((state == S_RECV || state == S_WAIT_STOP) && !ev_any) begin
                if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end

            if (commit && (!valid_q || rx.out_ready)) begin
                data_q  <= sr;
                valid_q <= 1'b1;
            end else if (valid_q && rx.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.data_out    = data_q;
    assign rx.out_valid   = valid_q;
    assign rx.err_parity  = p_par_q;
    assign rx.err_length  = p_len_q;
    assign rx.err_timeout = p_tmo_q;
    assign rx.overrun     = ovr_q;
    assign rx.busy        = (state == S_RECV) || (state == S_WAIT_STOP);
endmodule

// File: tb/tb_sl_rx_param.sv
// Scoreboard bench for sl_rx_param: frames are built from random data and the
// framing rules, expected words/errors are queued, a monitor pops on DUT output.
module tb_sl_rx_param;
    localparam int MB  = 32;
    localparam int FL  = 3;
    localparam int TO  = 64;
    localparam int BLW = $clog2(MB + 1);

    logic           clk = 1'b0;
    logic           reset, sl0, sl1;
    logic [1:0]     mode;
    logic [BLW-1:0] bit_len;

    logic [MB-1:0] exp_q[$];
    string         err_q[$];
    int            checks = 0;
    int            errors = 0;

    sl_rx_param_if #(.MAX_BITS(MB)) rxi ();

    sl_rx_param #(.MAX_BITS(MB), .FILT_LEN(FL), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .sl0     (sl0),
        .sl1     (sl1),
        .mode    (mode),
        .bit_len (bit_len),
        .rx      (rxi.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_err(input string nm, input logic p);
        string e;
        if (p) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL %s: pulse seen, expected no error pulse", nm);
            end else begin
                e = err_q.pop_front();
                if (e != nm) begin
                    errors++;
                    $display("FAIL err_kind: got %s expected %s", nm, e);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rxi.out_valid && rxi.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word: got 0x%0h expected no word", rxi.data_out);
                end else begin
                    check("word", 64'(rxi.data_out), 64'(exp_q.pop_front()));
                end
            end
            mon_err("err_parity",  rxi.err_parity);
            mon_err("err_length",  rxi.err_length);
            mon_err("err_timeout", rxi.err_timeout);
            mon_err("overrun",     rxi.overrun);
        end
    end

    function automatic int unsigned word_len(input logic [1:0] md, input int unsigned bl);
        int unsigned l;
        case (md)
            2'd0:    l = 8;
            2'd1:    l = 16;
            2'd2:    l = 32;
            default: l = (bl == 0 || bl > MB) ? MB : bl;
        endcase
        if (l > MB) l = MB;
        return l;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) sl1 = 1'b0;
        else   sl0 = 1'b0;
        wait_cyc($urandom_range(4, 7));
        sl0 = 1'b1;
        sl1 = 1'b1;
        wait_cyc($urandom_range(4, 9));
    endtask

    task automatic send_stop();
        sl0 = 1'b0;
        sl1 = 1'b0;
        wait_cyc($urandom_range(4, 7));
        sl0 = 1'b1;
        sl1 = 1'b1;
        wait_cyc(8);
    endtask

    task automatic glitch();
        sl0 = 1'b0;
        wait_cyc(FL - 1);
        sl0 = 1'b1;
        wait_cyc(3);
        sl1 = 1'b0;
        wait_cyc(FL - 1);
        sl1 = 1'b1;
        wait_cyc(3);
    endtask

    // kind: 0 good, 1 bad parity, 2 short, 3 extra bit, 4 good but expected overrun
    task automatic frame(input logic [1:0] md, input int unsigned bl, input int kind,
                         input logic [63:0] data, input int short_cnt, input bit glt);
        int unsigned n;
        int          nb;
        logic [63:0] w;
        logic [65:0] stream;
        n = word_len(md, bl);
        w = data & ((64'd1 << n) - 64'd1);
        stream = '0;
        for (int i = 0; i < int'(n); i++) stream[i] = w[i];
        stream[n]     = (kind == 1) ? ^w : ~^w;
        stream[n + 1] = 1'($urandom_range(0, 1));
        if (kind == 2)      nb = (short_cnt > 0) ? short_cnt : int'($urandom_range(1, n));
        else if (kind == 3) nb = int'(n) + 2;
        else                nb = int'(n) + 1;
        case (kind)
            0:       exp_q.push_back(w[MB-1:0]);
            1:       err_q.push_back("err_parity");
            4:       err_q.push_back("overrun");
            default: err_q.push_back("err_length");
        endcase
        mode    = md;
        bit_len = BLW'(bl);
        wait_cyc(2);
        for (int i = 0; i < nb; i++) begin
            send_bit(stream[i]);
            if (i == 0) begin
                mode    = 2'($urandom);
                bit_len = BLW'($urandom);
            end
            if (glt && i == 1) glitch();
        end
        send_stop();
    endtask

    task automatic drain(input bit words_too);
        wait_cyc(10);
        check("err_queue_left", 64'(err_q.size()), 64'd0);
        if (words_too) check("word_queue_left", 64'(exp_q.size()), 64'd0);
        check("busy_idle", 64'(rxi.busy), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int          r;
        reset         = 1'b1;
        sl0           = 1'b1;
        sl1           = 1'b1;
        mode          = 2'd0;
        bit_len       = '0;
        rxi.out_ready = 1'b1;
        #1;
        check("rst_data", 64'(rxi.data_out), 64'd0);
        check("rst_valid", 64'(rxi.out_valid), 64'd0);
        check("rst_busy", 64'(rxi.busy), 64'd0);
        check("rst_errs", 64'({rxi.err_parity, rxi.err_length, rxi.err_timeout, rxi.overrun}), 64'd0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);

        // Byte 0xA5 sent LSB first, then a short 16-bit frame, then recovery
        frame(2'd0, 0, 0, 64'hA5, 0, 1'b0);
        drain(1'b1);
        check("a5_data_held", 64'(rxi.data_out), 64'hA5);
        frame(2'd1, 0, 2, 64'h1234, 10, 1'b0);
        drain(1'b1);
        frame(2'd3, 5, 0, 64'h13, 0, 1'b0);
        frame(2'd3, 5, 1, 64'h13, 0, 1'b0);
        frame(2'd3, 1, 0, 64'h1, 0, 1'b0);
        frame(2'd3, 0, 0, 64'hDEADBEEF, 0, 1'b1);
        frame(2'd3, 40, 0, 64'hCAFEF00D, 0, 1'b0);
        frame(2'd1, 0, 3, 64'hBEEF, 0, 1'b0);
        drain(1'b1);

        // Held word plus a second commit with no consumer
        rxi.out_ready = 1'b0;
        frame(2'd0, 0, 0, 64'h3C, 0, 1'b0);
        frame(2'd0, 0, 4, 64'h5A, 0, 1'b0);
        wait_cyc(10);
        check("held_valid", 64'(rxi.out_valid), 64'd1);
        check("held_data", 64'(rxi.data_out), 64'h3C);
        rxi.out_ready = 1'b1;
        drain(1'b1);
        rxi.out_ready = 1'b0;
        frame(2'd0, 0, 0, 64'h81, 0, 1'b0);
        exp_q.push_back(MB'(64'h7E));
        mode = 2'd0;
        d = 64'h7E;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d[7:0]);
        rxi.out_ready = 1'b1;
        send_stop();
        drain(1'b1);

        // Stall inside a frame
        err_q.push_back("err_timeout");
        mode = 2'd0;
        wait_cyc(2);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("busy_in_frame", 64'(rxi.busy), 64'd1);
        wait_cyc(TO + 20);
        drain(1'b1);
        frame(2'd0, 0, 0, 64'h96, 0, 1'b1);
        drain(1'b1);

        // Reset in the middle of an 8-bit frame
        mode = 2'd0;
        wait_cyc(2);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("busy_before_rst", 64'(rxi.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_data", 64'(rxi.data_out), 64'd0);
        check("midrst_valid", 64'(rxi.out_valid), 64'd0);
        check("midrst_busy", 64'(rxi.busy), 64'd0);
        wait_cyc(3);
        reset = 1'b0;
        err_q.push_back("err_length");
        wait_cyc(3);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_stop();
        drain(1'b1);

        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            d = {$urandom, $urandom};
            frame(2'($urandom_range(0, 3)), $urandom_range(0, 40),
                  (r <= 5 || r == 9) ? 0 : r - 5, d, 0, r == 9);
            drain(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
